// File: rtl/spi_slave_frontend.sv
// SPI mode-0 slave front end: pin synchronisers, MOSI deserialiser with a one-byte
// holding register, MISO serialiser and frame/error reporting. Optional: SPI_OVERRUN_CNT_EN.
module spi_slave_frontend #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_MISO   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       frame_start,
  output logic       frame_end,
  output logic       overrun,
  output logic       underrun
`ifdef SPI_OVERRUN_CNT_EN
  ,
  output logic [7:0] overrun_cnt
`endif
);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   cs_hist, sclk_hist;

  // cs chain resets to "deasserted" so a held-low cs shows up as a fresh frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= '1;
      cs_hist   <= 1'b1;
      sclk_sync <= '0;
      sclk_hist <= 1'b0;
      mosi_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the previous stage's old value.
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      cs_hist   <= cs_sync[SYNC_STAGES-1];
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  logic cs_s, sclk_s, mosi_s;
  logic cs_active, cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic byte_done, load_tx, drop;

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;

  // NOTE: every signal gets a value on every path here, so no latches are inferred.
  always_comb begin
    cs_s      = cs_sync[SYNC_STAGES-1];
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    mosi_s    = mosi_sync[SYNC_STAGES-1];
    cs_active = ~cs_s;
    cs_fall   = cs_hist & ~cs_s;
    cs_rise   = ~cs_hist & cs_s;
    sclk_rise = ~sclk_hist & sclk_s;
    sclk_fall = sclk_hist & ~sclk_s;
    // A cs rise leaves cs_active low, so it always beats a coincident sclk edge.
    byte_done = cs_active & ~cs_fall & sclk_rise & (bit_cnt == 3'd7);
    load_tx   = cs_fall | byte_done;
    drop      = byte_done & rx_valid & ~rx_ready;
  end

  assign tx_ready    = ~rst & load_tx & tx_valid;
  assign spi_miso    = cs_active & tx_shift[7];
  assign spi_miso_oe = cs_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= cs_fall;
      frame_end   <= cs_rise;
      underrun    <= load_tx & ~tx_valid;

      if (load_tx)
        tx_shift <= tx_valid ? tx_data : IDLE_MISO;
      else if (cs_active && sclk_fall && bit_cnt != 3'd0)
        tx_shift <= {tx_shift[6:0], 1'b0};

      // Partial bytes are discarded at both frame boundaries.
      if (cs_fall || cs_rise) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (cs_active && sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= {rx_shift[5:0], mosi_s};
      end

      if (cs_fall)
        overrun <= 1'b0;
      else if (drop)
        overrun <= 1'b1;

      if (byte_done && (!rx_valid || rx_ready)) begin
        rx_data  <= {rx_shift, mosi_s};
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      overrun_cnt <= '0;
    else if (drop && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed bench for spi_slave_frontend: a bit-level SPI master, a byte-level receive
// model with an expected-byte queue, and a per-cycle compare process.
module tb_spi_slave_frontend;

  localparam int SYNC = 2;
  localparam int H    = 6;  // sclk half period in clk cycles
  localparam logic [7:0] IDLE = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, frame_start, frame_end, overrun, underrun;
`ifdef SPI_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  spi_slave_frontend #(.SYNC_STAGES(SYNC), .IDLE_MISO(IDLE)) dut (
    .clk(clk), .rst(rst),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_start(frame_start), .frame_end(frame_end),
    .overrun(overrun), .underrun(underrun)
`ifdef SPI_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Receive model: which bytes must be handed over, in order, and the overrun state.
  logic [7:0] exp_q[$];
  logic       model_held = 1'b0;
  logic       model_ovr  = 1'b0;
  int         model_ocnt = 0;

  task automatic model_byte(input logic [7:0] b);
    if (rx_ready || !model_held) begin
      exp_q.push_back(b);
      model_held = !rx_ready;
    end else begin
      model_ovr = 1'b1;
      if (model_ocnt < 255) model_ocnt++;
    end
  endtask

  // cs as the DUT sees it after synchronisation: the pin value SYNC clk edges ago.
  logic [SYNC-1:0] cs_m = '1;
  always @(posedge clk) begin
    if (rst) cs_m <= '1;
    else     cs_m <= {cs_m[SYNC-2:0], spi_cs_n};
  end

  int n_fs = 0, n_fe = 0, n_txr = 0, n_ur = 0, n_acc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("miso_oe", spi_miso_oe, !cs_m[SYNC-1]);
      if (!spi_miso_oe) check("miso_idle", spi_miso, 1'b0);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_order: got unexpected byte %0h, expected none", rx_data);
        end else begin
          check("rx_order", rx_data, exp_q.pop_front());
        end
        n_acc++;
      end
      if (frame_start) n_fs++;
      if (frame_end)   n_fe++;
      if (tx_ready)    n_txr++;
      if (underrun)    n_ur++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs_n  = 1'b0;
    model_ovr = 1'b0;
    tick(SYNC + 4);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    tick(SYNC + 4);
  endtask

  // Mode 0 master: MOSI set while sclk low, MISO sampled as sclk rises.
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      tick(H);
      spi_sclk = 1'b1;
      miso_b   = {miso_b[6:0], spi_miso};
      tick(H);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic set_ready(input logic r);
    rx_ready = r;
    if (r) model_held = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    int fs0, fe0, txr0, ur0, acc0, k;
    bit found;

    // Reset state
    tick(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_oe", spi_miso_oe, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    rst = 1'b0;
    tick(2);

    // Single byte A5 in, 3C out
    tx_valid = 1'b1; tx_data = 8'h3C; set_ready(1'b0);
    fs0 = n_fs; txr0 = n_txr;
    cs_low();
    check("t1_frame_start", n_fs - fs0, 1);
    check("t1_tx_ready_start", n_txr - txr0, 1);
    model_byte(8'hA5);
    spi_bits(8'hA5, 8, m);
    tick(2);
    check("t1_miso", m, 8'h3C);
    check("t1_rx_valid", rx_valid, 1'b1);
    check("t1_rx_data", rx_data, 8'hA5);
    check("t1_tx_ready_total", n_txr - txr0, 2);
    acc0 = n_acc;
    set_ready(1'b1);
    tick(2);
    check("t1_accept", n_acc - acc0, 1);
    fe0 = n_fe;
    cs_high();
    check("t1_frame_end", n_fe - fe0, 1);

    // Three bytes, consumer always ready
    acc0 = n_acc;
    cs_low();
    for (int i = 1; i <= 3; i++) begin
      model_byte(8'(i));
      spi_bits(8'(i), 8, m);
    end
    tick(4);
    check("t2_accepts", n_acc - acc0, 3);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_overrun", overrun, 1'b0);
    cs_high();

    // Overrun: consumer stalled across two bytes
    set_ready(1'b0);
    cs_low();
    model_byte(8'h11); spi_bits(8'h11, 8, m);
    model_byte(8'h22); spi_bits(8'h22, 8, m);
    tick(2);
    check("t3_rx_data", rx_data, 8'h11);
    check("t3_rx_valid", rx_valid, 1'b1);
    check("t3_overrun_lit", overrun, 1'b1);
    check("t3_overrun_model", overrun, model_ovr);
`ifdef SPI_OVERRUN_CNT_EN
    check("t3_overrun_cnt", overrun_cnt, 8'd1);
`endif
    cs_high();
    cs_low();
    check("t3_overrun_clr", overrun, model_ovr);
    acc0 = n_acc;
    set_ready(1'b1);
    tick(2);
    check("t3_drain", n_acc - acc0, 1);
    cs_high();

    // Underrun: no tx byte available
    tx_valid = 1'b0;
    ur0 = n_ur; txr0 = n_txr;
    cs_low();
    model_byte(8'h5A);
    spi_bits(8'h5A, 8, m);
    tick(2);
    check("t4_miso_idle", m, IDLE);
    check("t4_underrun", n_ur - ur0, 2);
    check("t4_no_tx_ready", n_txr - txr0, 0);
    cs_high();

    // Aborted partial byte, then realignment
    set_ready(1'b0);
    acc0 = n_acc; fe0 = n_fe;
    cs_low();
    spi_bits(8'hFF, 5, m);
    cs_high();
    check("t5_frame_end", n_fe - fe0, 1);
    check("t5_no_rx_valid", rx_valid, 1'b0);
    check("t5_no_accept", n_acc - acc0, 0);
    cs_low();
    model_byte(8'hC3);
    spi_bits(8'hC3, 8, m);
    tick(2);
    check("t5_rx_valid", rx_valid, 1'b1);
    check("t5_rx_data", rx_data, 8'hC3);
    set_ready(1'b1);
    tick(2);
    check("t5_accept", n_acc - acc0, 1);
    cs_high();

    // Reset mid-byte with cs held low
    tx_valid = 1'b1; tx_data = 8'h96;
    fe0 = n_fe;
    cs_low();
    spi_bits(8'h0F, 3, m);
    rst = 1'b1;
    tick(1);
    check("t6_rx_valid", rx_valid, 1'b0);
    check("t6_rx_data", rx_data, 8'h00);
    check("t6_overrun", overrun, 1'b0);
    check("t6_oe", spi_miso_oe, 1'b0);
    check("t6_miso", spi_miso, 1'b0);
    check("t6_tx_ready", tx_ready, 1'b0);
    check("t6_pulses", {frame_start, frame_end, underrun}, 3'b000);
`ifdef SPI_OVERRUN_CNT_EN
    check("t6_overrun_cnt", overrun_cnt, 8'd0);
`endif
    exp_q.delete();
    model_held = 1'b0; model_ovr = 1'b0; model_ocnt = 0;
    rst = 1'b0;
    found = 1'b0; k = 0;
    while (!found && k < 20) begin
      tick(1);
      k++;
      if (frame_start) found = 1'b1;
    end
    check("t6_fs_latency", k, SYNC + 1);
    check("t6_no_frame_end", n_fe - fe0, 0);
    cs_high();
    acc0 = n_acc;
    cs_low();
    model_byte(8'h69);
    spi_bits(8'h69, 8, m);
    tick(4);
    check("t6_resync_miso", m, 8'h96);
    check("t6_resync_accept", n_acc - acc0, 1);
    check("t6_queue_empty", exp_q.size(), 0);
`ifdef SPI_OVERRUN_CNT_EN
    check("t6_overrun_cnt_model", overrun_cnt, model_ocnt);
`endif
    cs_high();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
